set_mode_ctrl: RTL

User-input controller for the clock/calendar counter chain. It turns three raw push-buttons (set, up, down) into the one-hot field-select strobes (`mode_second` … `mode_year`) and single-cycle `up`/`down` pulses that drive the counter bank. Held buttons auto-repeat. It also supplies a blink phase so the display can flash the field being edited. It sits between the button pads and the counter bank; the counter bank's outputs are not fed back.

---
 rtl/set_mode_ctrl.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/set_mode_ctrl.sv
// set_mode_ctrl
// User-input controller for the clock/calendar counter chain. Conditions three
// raw push-buttons, walks the field-select state machine on set presses,
// produces single-cycle up/down pulses with auto-repeat while a button is held,
// and supplies a blink phase for the field being edited.
//
// Optional feature macro: SET_MODE_CTRL_TIMEOUT_EN
//   defined   -> idle timer returns SET states to RUN after TIMEOUT idle cycles
//   undefined -> no idle timer; SET states exit only through the set sequence
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   btn_set, btn_up, btn_down     raw button levels (asynchronous, 1 = pressed)
//   mode_second .. mode_year      registered one-hot field selects (0 in RUN)
//   up, down                      one-cycle adjust pulses
//   editing                       high in any SET state
//   blink                         display-enable phase for the selected field
module set_mode_ctrl #(
    parameter logic [23:0] REPEAT_DELAY = 24'd5_000_000,
    parameter logic [23:0] REPEAT_RATE  = 24'd1_000_000,
    parameter logic [31:0] TIMEOUT      = 32'd500_000_000,
    parameter logic [23:0] BLINK_HALF   = 24'd2_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_set,
    input  logic btn_up,
    input  logic btn_down,
    output logic mode_second,
    output logic mode_minute,
    output logic mode_hour,
    output logic mode_day,
    output logic mode_month,
    output logic mode_year,
    output logic up,
    output logic down,
    output logic editing,
    output logic blink
);
    typedef enum logic [2:0] {
        RUN      = 3'd0,
        SET_SEC  = 3'd1,
        SET_MIN  = 3'd2,
        SET_HOUR = 3'd3,
        SET_DAY  = 3'd4,
        SET_MON  = 3'd5,
        SET_YEAR = 3'd6
    } state_t;

    state_t state_q, state_d;

    // Button vectors: bit 0 = set, bit 1 = up, bit 2 = down.
    // lvl_q is the synced level delayed one cycle so it lines up with edge_q.
    logic [2:0] meta_q, sync_q, lvl_q, edge_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            lvl_q  <= '0;
            edge_q <= '0;
        end else begin
            meta_q <= {btn_down, btn_up, btn_set};
            sync_q <= meta_q;
            lvl_q  <= sync_q;
            edge_q <= sync_q & ~lvl_q;
        end
    end

    logic set_edge, up_lvl, dn_lvl, up_edge, dn_edge;
    assign set_edge = edge_q[0];
    assign up_lvl   = lvl_q[1];
    assign dn_lvl   = lvl_q[2];
    assign up_edge  = edge_q[1];
    assign dn_edge  = edge_q[2];

    logic timeout;
`ifdef SET_MODE_CTRL_TIMEOUT_EN
    logic [31:0] idle_q, idle_d;

    always_comb begin
        idle_d = idle_q;
        if (|lvl_q)
            idle_d = '0;
        else if (idle_q != '1)
            idle_d = idle_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) idle_q <= '0;
        else     idle_q <= idle_d;
    end

    assign timeout = (state_q != RUN) && (idle_q == TIMEOUT);
`else
    // Keeps the parameter referenced when the idle timer is compiled out.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout = 1'b0;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        if (set_edge) begin
            case (state_q)
                RUN:      state_d = SET_SEC;
                SET_SEC:  state_d = SET_MIN;
                SET_MIN:  state_d = SET_HOUR;
                SET_HOUR: state_d = SET_DAY;
                SET_DAY:  state_d = SET_MON;
                SET_MON:  state_d = SET_YEAR;
                default:  state_d = RUN;
            endcase
        end else if (timeout) begin
            state_d = RUN;
        end
    end

    logic state_chg;
    assign state_chg = (state_d != state_q);

    // ---------------- press / auto-repeat ----------------
    // rpt_q counts cycles since the last pulse of the current press; the
    // threshold is REPEAT_DELAY until the first repeat, REPEAT_RATE after.
    // active_q is cleared by anything that ends a press (release, both
    // buttons, state change), so a button held across a state change has to
    // be released and pressed again before it pulses.
    logic [23:0] rpt_q, rpt_d;
    logic        active_q, active_d;
    logic        dir_q, dir_d;        // 0 = up, 1 = down
    logic        rep_q, rep_d;
    logic        pulse_up, pulse_dn;

    always_comb begin
        rpt_d    = '0;
        active_d = 1'b0;
        dir_d    = dir_q;
        rep_d    = 1'b0;
        pulse_up = 1'b0;
        pulse_dn = 1'b0;
        if (state_q != RUN && !state_chg && (up_lvl ^ dn_lvl)) begin
            if (up_lvl ? up_edge : dn_edge) begin
                pulse_up = up_lvl;
                pulse_dn = dn_lvl;
                active_d = 1'b1;
                dir_d    = dn_lvl;
                rpt_d    = 24'd1;
            end else if (active_q && (dir_q == dn_lvl)) begin
                active_d = 1'b1;
                if (rpt_q >= (rep_q ? REPEAT_RATE : REPEAT_DELAY)) begin
                    pulse_up = up_lvl;
                    pulse_dn = dn_lvl;
                    rpt_d    = 24'd1;
                    rep_d    = 1'b1;
                end else begin
                    rpt_d = (rpt_q == '1) ? rpt_q : rpt_q + 24'd1;
                    rep_d = rep_q;
                end
            end
        end
    end

    // ---------------- blink phase ----------------
    logic [23:0] bcnt_q, bcnt_d;
    logic        blink_d;

    always_comb begin
        blink_d = blink;
        bcnt_d  = bcnt_q;
        if (state_d == RUN || state_chg || pulse_up || pulse_dn) begin
            blink_d = 1'b1;
            bcnt_d  = '0;
        end else if (bcnt_q >= BLINK_HALF - 24'd1) begin
            blink_d = ~blink;
            bcnt_d  = '0;
        end else begin
            bcnt_d = bcnt_q + 24'd1;
        end
    end

    // ---------------- output decode ----------------
    logic [5:0] mode_d;
    logic       editing_d;

    always_comb begin
        mode_d = '0;
        case (state_d)
            SET_SEC:  mode_d[0] = 1'b1;
            SET_MIN:  mode_d[1] = 1'b1;
            SET_HOUR: mode_d[2] = 1'b1;
            SET_DAY:  mode_d[3] = 1'b1;
            SET_MON:  mode_d[4] = 1'b1;
            SET_YEAR: mode_d[5] = 1'b1;
            default:  mode_d    = '0;
        endcase
        editing_d = (state_d != RUN);
    end

    logic [5:0] mode_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= '0;
            editing  <= 1'b0;
            up       <= 1'b0;
            down     <= 1'b0;
            blink    <= 1'b1;
            bcnt_q   <= '0;
            rpt_q    <= '0;
            active_q <= 1'b0;
            dir_q    <= 1'b0;
            rep_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            editing  <= editing_d;
            up       <= pulse_up;
            down     <= pulse_dn;
            blink    <= blink_d;
            bcnt_q   <= bcnt_d;
            rpt_q    <= rpt_d;
            active_q <= active_d;
            dir_q    <= dir_d;
            rep_q    <= rep_d;
        end
    end

    assign {mode_year, mode_month, mode_day, mode_hour, mode_minute, mode_second} = mode_q;

endmodule
